// File: rtl/tri_pkg.sv
// Shared types and constants for the triangle list controller and its storage.
package tri_pkg;

    localparam int WI        = 8;
    localparam int WF        = 8;
    localparam int CW        = WI + WF;
    localparam int TRI_DEPTH = 16;
    localparam int TRI_AW    = 4;
    localparam int CUBE_TRIS = 12;

    typedef logic [2:0][2:0][CW-1:0] triangle_t;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        READY,
        ISSUE,
        DONE
    } state_t;

endpackage

// File: rtl/tri_list_ctrl_if.sv
// Loader, render-request and triangle-stream signals of the triangle list controller.
interface tri_list_ctrl_if #(
    parameter int AW = tri_pkg::TRI_AW
);
    import tri_pkg::*;

    logic            load_obj;
    logic            list_w;
    triangle_t       orig_triangle_in;
    logic            load_done;
    logic            frame_start;
    triangle_t       tri_out;
    logic            tri_valid;
    logic            tri_ready;
    logic            frame_busy;
    logic            frame_done;
    logic [AW:0]     tri_count;
    logic            overflow;

    modport slave (
        input  load_obj, list_w, orig_triangle_in, load_done, frame_start, tri_ready,
        output tri_out, tri_valid, frame_busy, frame_done, tri_count, overflow
    );

    modport master (
        output load_obj, list_w, orig_triangle_in, load_done, frame_start, tri_ready,
        input  tri_out, tri_valid, frame_busy, frame_done, tri_count, overflow
    );

endinterface

// File: rtl/tri_list_mem.sv
// Triangle register array: one synchronous write port and one registered read port.
// The read register clears on reset; the array contents do not.
module tri_list_mem
    import tri_pkg::*;
#(
    parameter int DEPTH = TRI_DEPTH,
    parameter int AW    = TRI_AW
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  triangle_t     wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output triangle_t     rd_data
);

    triangle_t mem [DEPTH];

    always_ff @(posedge Clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/tri_list_ctrl.sv
// Triangle list controller: stores the loaded object and streams every triangle
// once per frame to the transform stage, keeping loading and rendering exclusive.
module tri_list_ctrl
    import tri_pkg::*;
#(
    parameter int DEPTH = TRI_DEPTH,
    parameter int AW    = TRI_AW
) (
    input logic            Clk,
    input logic            Reset,
    tri_list_ctrl_if.slave bus
);

    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE  = (AW+1)'(1);

    state_t        state;
    logic [AW:0]   tri_count;
    logic [AW:0]   rd_ptr;
    logic          tri_valid;
    logic          frame_done;
    logic          overflow;
    triangle_t     tri_out;

    logic          handshake;
    logic          start_pass;
    logic          advance;
    logic          wr_en;
    logic          rd_en;
    logic [AW-1:0] rd_addr;

    // The memory read register doubles as tri_out, so reads are launched on
    // the same edge that the FSM starts or advances the pass.
    always_comb begin
        handshake  = tri_valid && bus.tri_ready;
        start_pass = (state == READY) && bus.frame_start && !bus.load_obj
                     && (tri_count != '0);
        advance    = (state == ISSUE) && handshake && (rd_ptr < tri_count);
        wr_en      = (state == LOAD) && bus.list_w && (tri_count < FULL);
        rd_en      = start_pass || advance;
        rd_addr    = start_pass ? '0 : rd_ptr[AW-1:0];
    end

    tri_list_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .Clk     (Clk),
        .Reset   (Reset),
        .wr_en   (wr_en),
        .wr_addr (tri_count[AW-1:0]),
        .wr_data (bus.orig_triangle_in),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (tri_out)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state      <= IDLE;
            tri_count  <= '0;
            rd_ptr     <= '0;
            tri_valid  <= 1'b0;
            frame_done <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.load_obj) begin
                        state     <= LOAD;
                        tri_count <= '0;
                        overflow  <= 1'b0;
                    end
                end
                LOAD: begin
                    if (bus.list_w) begin
                        if (tri_count < FULL) begin
                            tri_count <= tri_count + ONE;
                        end else begin
                            overflow <= 1'b1;
                        end
                    end
                    if (bus.load_done) begin
                        state <= READY;
                    end
                end
                READY: begin
                    if (bus.load_obj) begin
                        state     <= LOAD;
                        tri_count <= '0;
                        overflow  <= 1'b0;
                    end else if (bus.frame_start) begin
                        if (tri_count != '0) begin
                            state     <= ISSUE;
                            rd_ptr    <= ONE;
                            tri_valid <= 1'b1;
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                ISSUE: begin
                    if (handshake) begin
                        if (rd_ptr < tri_count) begin
                            rd_ptr <= rd_ptr + ONE;
                        end else begin
                            tri_valid  <= 1'b0;
                            frame_done <= 1'b1;
                            state      <= DONE;
                        end
                    end
                end
                DONE: begin
                    // An empty pass enters DONE without the pulse raised, so it
                    // spends one extra cycle here to raise it.
                    if (frame_done) begin
                        frame_done <= 1'b0;
                        state      <= READY;
                    end else begin
                        frame_done <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.tri_out    = tri_out;
    assign bus.tri_valid  = tri_valid;
    assign bus.frame_busy = (state == ISSUE);
    assign bus.frame_done = frame_done;
    assign bus.tri_count  = tri_count;
    assign bus.overflow   = overflow;

endmodule

// File: tb/tb_tri_list_ctrl.sv
// Directed bench for tri_list_ctrl: a per-cycle vector table for control behaviour
// plus modelled passes for streaming, backpressure, overflow and mid-pass reset.
module tb_tri_list_ctrl;
    import tri_pkg::*;

    typedef struct {
        logic       rst, lo, lw, ld, fs, rdy;
        int         widx;
        logic       ev, ed, eb;
        logic [4:0] ec;
        logic       eo;
        int         eidx;
    } vec_t;

    localparam int NV = 19;

    logic Clk;
    logic Reset;
    int   n_vec;
    int   n_err;

    tri_list_ctrl_if #(.AW(4)) bus ();

    tri_list_ctrl dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic triangle_t mk_tri(input int k);
        triangle_t t;
        for (int v = 0; v < 3; v++) begin
            for (int c = 0; c < 3; c++) begin
                t[v][c] = 16'(k * 256 + v * 16 + c + 1);
            end
        end
        return t;
    endfunction

    function automatic vec_t mk_vec(input int rst, input int lo, input int lw, input int ld,
                                    input int fs, input int rdy, input int widx,
                                    input int ev, input int ed, input int eb,
                                    input int ec, input int eo, input int eidx);
        vec_t r;
        r.rst  = 1'(rst);
        r.lo   = 1'(lo);
        r.lw   = 1'(lw);
        r.ld   = 1'(ld);
        r.fs   = 1'(fs);
        r.rdy  = 1'(rdy);
        r.widx = widx;
        r.ev   = 1'(ev);
        r.ed   = 1'(ed);
        r.eb   = 1'(eb);
        r.ec   = 5'(ec);
        r.eo   = 1'(eo);
        r.eidx = eidx;
        return r;
    endfunction

    task automatic chk1(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got %0b, expected %0b", name, act, exp);
        end
    endtask

    task automatic chk5(input string name, input logic [4:0] act, input logic [4:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chkt(input string name, input triangle_t act, input triangle_t exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic load_tris(input int base, input int n);
        bus.load_obj = 1'b1;
        tick();
        bus.load_obj = 1'b0;
        for (int i = 0; i < n; i++) begin
            bus.list_w           = 1'b1;
            bus.orig_triangle_in = mk_tri(base + i);
            tick();
        end
        bus.list_w    = 1'b0;
        bus.load_done = 1'b1;
        tick();
        bus.load_done = 1'b0;
    endtask

    // mode 0: ready always high; mode 1: ready 1,0,0 repeating;
    // mode 2: ready high with frame_start and load_obj pushed during ISSUE.
    task automatic run_pass(input int base, input int n, input int mode);
        int k;
        int cyc;
        bit ev;
        bit ed;
        bit fin;
        k   = 0;
        cyc = 0;
        ev  = 1'b1;
        ed  = 1'b0;
        fin = 1'b0;
        bus.frame_start = 1'b1;
        bus.tri_ready   = 1'b0;
        tick();
        bus.frame_start = 1'b0;
        while (!fin) begin
            chk1("pass_valid", bus.tri_valid, ev);
            chk1("pass_done", bus.frame_done, ed);
            chk1("pass_busy", bus.frame_busy, ev);
            if (ev) begin
                chkt($sformatf("pass_data%0d", k), bus.tri_out, mk_tri(base + k));
            end
            if (ed) begin
                fin = 1'b1;
            end else begin
                bus.tri_ready   = (mode == 1) ? (cyc % 3 == 0) : 1'b1;
                bus.frame_start = (mode == 2) && ev;
                bus.load_obj    = (mode == 2) && ev;
                ed = 1'b0;
                if (ev && bus.tri_ready) begin
                    if (k == n - 1) begin
                        ev = 1'b0;
                        ed = 1'b1;
                    end else begin
                        k++;
                    end
                end
                tick();
                cyc++;
            end
        end
        bus.tri_ready   = 1'b0;
        bus.frame_start = 1'b0;
        bus.load_obj    = 1'b0;
        tick();
        chk1("post_pass_done", bus.frame_done, 1'b0);
        chk1("post_pass_valid", bus.tri_valid, 1'b0);
    endtask

    task automatic applyStimulus();
        vec_t tbl [NV];
        tbl[0]  = mk_vec(1,0,0,0,0,0, 0,  0,0,0,0,0,-1);
        tbl[1]  = mk_vec(0,0,0,0,1,1, 0,  0,0,0,0,0,-1);
        tbl[2]  = mk_vec(0,1,0,0,0,0, 0,  0,0,0,0,0,-1);
        tbl[3]  = mk_vec(0,0,1,0,0,0, 10, 0,0,0,1,0,-1);
        tbl[4]  = mk_vec(0,1,1,0,1,0, 11, 0,0,0,2,0,-1);
        tbl[5]  = mk_vec(0,0,1,1,0,0, 12, 0,0,0,3,0,-1);
        tbl[6]  = mk_vec(0,0,0,0,0,0, 0,  0,0,0,3,0,-1);
        tbl[7]  = mk_vec(0,0,0,0,1,0, 0,  1,0,1,3,0,10);
        tbl[8]  = mk_vec(0,0,0,0,0,0, 0,  1,0,1,3,0,10);
        tbl[9]  = mk_vec(0,0,0,0,0,1, 0,  1,0,1,3,0,11);
        tbl[10] = mk_vec(0,1,0,0,1,0, 0,  1,0,1,3,0,11);
        tbl[11] = mk_vec(0,0,0,0,0,1, 0,  1,0,1,3,0,12);
        tbl[12] = mk_vec(0,0,0,0,0,1, 0,  0,1,0,3,0,-2);
        tbl[13] = mk_vec(0,0,0,0,0,1, 0,  0,0,0,3,0,-2);
        tbl[14] = mk_vec(0,1,0,0,1,0, 0,  0,0,0,0,0,-2);
        tbl[15] = mk_vec(0,0,0,1,0,0, 0,  0,0,0,0,0,-2);
        tbl[16] = mk_vec(0,0,0,0,1,0, 0,  0,0,0,0,0,-2);
        tbl[17] = mk_vec(0,0,0,0,0,0, 0,  0,1,0,0,0,-2);
        tbl[18] = mk_vec(0,0,0,0,0,0, 0,  0,0,0,0,0,-2);
        for (int i = 0; i < NV; i++) begin
            Reset                = tbl[i].rst;
            bus.load_obj         = tbl[i].lo;
            bus.list_w           = tbl[i].lw;
            bus.load_done        = tbl[i].ld;
            bus.frame_start      = tbl[i].fs;
            bus.tri_ready        = tbl[i].rdy;
            bus.orig_triangle_in = mk_tri(tbl[i].widx);
            tick();
            chk1($sformatf("row%0d_valid", i), bus.tri_valid, tbl[i].ev);
            chk1($sformatf("row%0d_done", i), bus.frame_done, tbl[i].ed);
            chk1($sformatf("row%0d_busy", i), bus.frame_busy, tbl[i].eb);
            chk5($sformatf("row%0d_count", i), bus.tri_count, tbl[i].ec);
            chk1($sformatf("row%0d_ovf", i), bus.overflow, tbl[i].eo);
            if (tbl[i].eidx == -1) begin
                chkt($sformatf("row%0d_out", i), bus.tri_out, '0);
            end else if (tbl[i].eidx >= 0) begin
                chkt($sformatf("row%0d_out", i), bus.tri_out, mk_tri(tbl[i].eidx));
            end
        end
        bus.load_obj    = 1'b0;
        bus.list_w      = 1'b0;
        bus.load_done   = 1'b0;
        bus.frame_start = 1'b0;
        bus.tri_ready   = 1'b0;
    endtask

    task automatic checkOutput();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        load_tris(100, CUBE_TRIS);
        chk5("cube_count", bus.tri_count, 5'd12);
        chk1("cube_ovf", bus.overflow, 1'b0);
        chk1("cube_valid_idle", bus.tri_valid, 1'b0);
        run_pass(100, CUBE_TRIS, 0);
        run_pass(100, CUBE_TRIS, 1);
        run_pass(100, CUBE_TRIS, 2);
        chk5("ignored_count", bus.tri_count, 5'd12);

        load_tris(200, 18);
        chk5("ovf_count", bus.tri_count, 5'd16);
        chk1("ovf_flag", bus.overflow, 1'b1);
        run_pass(200, 16, 0);
        bus.load_obj = 1'b1;
        tick();
        bus.load_obj = 1'b0;
        chk5("reload_count", bus.tri_count, 5'd0);
        chk1("reload_ovf", bus.overflow, 1'b0);
        bus.load_done = 1'b1;
        tick();
        bus.load_done = 1'b0;

        load_tris(100, CUBE_TRIS);
        bus.frame_start = 1'b1;
        bus.tri_ready   = 1'b1;
        tick();
        bus.frame_start = 1'b0;
        chk1("abort_valid0", bus.tri_valid, 1'b1);
        chkt("abort_data0", bus.tri_out, mk_tri(100));
        for (int i = 1; i <= 5; i++) begin
            tick();
            chkt($sformatf("abort_data%0d", i), bus.tri_out, mk_tri(100 + i));
        end
        Reset         = 1'b1;
        bus.tri_ready = 1'b0;
        tick();
        Reset = 1'b0;
        chk1("abort_valid", bus.tri_valid, 1'b0);
        chk5("abort_count", bus.tri_count, 5'd0);
        chk1("abort_done", bus.frame_done, 1'b0);
        chk1("abort_busy", bus.frame_busy, 1'b0);
        chkt("abort_out", bus.tri_out, '0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk1($sformatf("abort_nodone%0d", i), bus.frame_done, 1'b0);
            chk1($sformatf("abort_novalid%0d", i), bus.tri_valid, 1'b0);
        end
    endtask

    initial begin
        n_vec                = 0;
        n_err                = 0;
        Reset                = 1'b1;
        bus.load_obj         = 1'b0;
        bus.list_w           = 1'b0;
        bus.load_done        = 1'b0;
        bus.frame_start      = 1'b0;
        bus.tri_ready        = 1'b0;
        bus.orig_triangle_in = '0;
        applyStimulus();
        checkOutput();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
